// File: rtl/ulpb_lc_handshake_pkg.sv
// rtl/ulpb_lc_handshake_pkg.sv - shared widths, IO levels and FSM encodings for the LC handshake endpoint
package ulpb_lc_handshake_pkg;

    localparam int ULPB_ADDR_WIDTH = 8;
    localparam int ULPB_DATA_WIDTH = 32;

    // Isolation control levels, identical to the always-on domain definitions.
    localparam logic IO_HOLD    = 1'b1;
    localparam logic IO_RELEASE = 1'b0;

    typedef enum logic {
        RX_IDLE,
        RX_ACKED
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_REQ_HI,
        TX_ACK_LO,
        TX_WAIT_RESP,
        TX_RESP
    } tx_state_t;

    // A simultaneous success and failure report is treated as a failure.
    function automatic logic resp_is_succ(input logic succ, input logic fail);
        return succ & ~fail;
    endfunction

endpackage

// File: rtl/ulpb_sync2.sv
// rtl/ulpb_sync2.sv - two-flop level synchronizer
// Ports: clk, rst_n (async active-low), d (asynchronous level), q (synchronized level)
module ulpb_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ulpb_lc_handshake.sv
// rtl/ulpb_lc_handshake.sv - layer-side terminator of the BC<->LC four-phase RX/TX handshakes
// Ports: CLK/RESETn; RX_* from/to the bus controller; TX_*, PRIORITY, TX_RESP_ACK towards it;
//        USR_RX_* FIFO head and fail pulse to layer logic; USR_TX_* word offer and completion status.
module ulpb_lc_handshake
    import ulpb_lc_handshake_pkg::*;
#(
    parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_REQ,
    input  logic                  RX_PEND,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_PEND,
    output logic                  TX_REQ,
    output logic                  PRIORITY,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK,
    output logic                  USR_RX_VALID,
    input  logic                  USR_RX_READY,
    output logic [ADDR_WIDTH-1:0] USR_RX_ADDR,
    output logic [DATA_WIDTH-1:0] USR_RX_DATA,
    output logic                  USR_RX_PEND,
    output logic                  USR_RX_FAIL,
    input  logic                  USR_TX_VALID,
    output logic                  USR_TX_READY,
    input  logic [ADDR_WIDTH-1:0] USR_TX_ADDR,
    input  logic [DATA_WIDTH-1:0] USR_TX_DATA,
    input  logic                  USR_TX_PEND,
    input  logic                  USR_TX_PRIO,
    output logic                  USR_TX_DONE,
    output logic                  USR_TX_SUCC
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(RX_DEPTH);

    // ------------------------------------------------------------------
    // Synchronizers for the asynchronous control levels
    // ------------------------------------------------------------------
    logic rx_req_s, rx_fail_s, tx_ack_s, tx_succ_s, tx_fail_s;

    ulpb_sync2 u_sync_rx_req  (.clk(CLK), .rst_n(RESETn), .d(RX_REQ),  .q(rx_req_s));
    ulpb_sync2 u_sync_rx_fail (.clk(CLK), .rst_n(RESETn), .d(RX_FAIL), .q(rx_fail_s));
    ulpb_sync2 u_sync_tx_ack  (.clk(CLK), .rst_n(RESETn), .d(TX_ACK),  .q(tx_ack_s));
    ulpb_sync2 u_sync_tx_succ (.clk(CLK), .rst_n(RESETn), .d(TX_SUCC), .q(tx_succ_s));
    ulpb_sync2 u_sync_tx_fail (.clk(CLK), .rst_n(RESETn), .d(TX_FAIL), .q(tx_fail_s));

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   rx_count;
    logic          fifo_full;
    logic          rx_push, rx_pop;

    assign fifo_full    = (rx_count == FULL_CNT);
    assign USR_RX_VALID = (rx_count != '0);
    assign rx_pop       = USR_RX_VALID && USR_RX_READY;
    assign {USR_RX_ADDR, USR_RX_DATA, USR_RX_PEND} = fifo_mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                fifo_mem[wr_ptr] <= {RX_ADDR, RX_DATA, RX_PEND};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t rx_state, rx_state_nxt;
    logic      rx_ack_nxt;

    // A full FIFO withholds the acknowledge; that is the only backpressure the BC sees.
    assign rx_push = (rx_state == RX_IDLE) && rx_req_s && !fifo_full;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_state <= RX_IDLE;
            RX_ACK   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            RX_ACK   <= rx_ack_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_push)   rx_state_nxt = RX_ACKED;
            RX_ACKED: if (!rx_req_s) rx_state_nxt = RX_IDLE;
            default:                 rx_state_nxt = RX_IDLE;
        endcase
    end

    // Handshake outputs cross to the BC domain, so they come straight from flops.
    always_comb begin
        rx_ack_nxt = (rx_state_nxt == RX_ACKED);
    end

    logic rx_fail_d;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_fail_d   <= 1'b0;
            USR_RX_FAIL <= 1'b0;
        end else begin
            rx_fail_d   <= rx_fail_s;
            USR_RX_FAIL <= rx_fail_s && !rx_fail_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t tx_state, tx_state_nxt;
    logic      tx_resp_s;
    logic      msg_active;
    logic      tx_abort;
    logic      tx_accept;
    logic      tx_status;
    logic      tx_req_nxt, tx_resp_ack_nxt, tx_done_nxt;

    assign tx_resp_s = tx_succ_s || tx_fail_s;

    // A response outside the wait state is an early abort by the BC. In ACK_LO it only
    // counts while ACK is still high; once ACK is low the word has completed normally and
    // the response is picked up by the following state.
    always_comb begin
        tx_abort = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_abort = tx_resp_s && msg_active;
            TX_REQ_HI: tx_abort = tx_resp_s;
            TX_ACK_LO: tx_abort = tx_resp_s && tx_ack_s;
            default:   tx_abort = 1'b0;
        endcase
    end

    assign USR_TX_READY = (tx_state == TX_IDLE) && !tx_abort;
    assign tx_accept    = USR_TX_READY && USR_TX_VALID;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_state    <= TX_IDLE;
            TX_REQ      <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            USR_TX_DONE <= 1'b0;
        end else begin
            tx_state    <= tx_state_nxt;
            TX_REQ      <= tx_req_nxt;
            TX_RESP_ACK <= tx_resp_ack_nxt;
            USR_TX_DONE <= tx_done_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (tx_abort)       tx_state_nxt = TX_RESP;
                else if (tx_accept) tx_state_nxt = TX_REQ_HI;
            end
            TX_REQ_HI: begin
                if (tx_abort)      tx_state_nxt = TX_RESP;
                else if (tx_ack_s) tx_state_nxt = TX_ACK_LO;
            end
            TX_ACK_LO: begin
                if (tx_abort)       tx_state_nxt = TX_RESP;
                else if (!tx_ack_s) tx_state_nxt = TX_PEND ? TX_IDLE : TX_WAIT_RESP;
            end
            TX_WAIT_RESP: if (tx_resp_s)  tx_state_nxt = TX_RESP;
            TX_RESP:      if (!tx_resp_s) tx_state_nxt = TX_IDLE;
            default:                      tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_req_nxt      = (tx_state_nxt == TX_REQ_HI);
        tx_resp_ack_nxt = (tx_state_nxt == TX_RESP);
        tx_done_nxt     = (tx_state == TX_RESP) && (tx_state_nxt == TX_IDLE);
    end

    // TX datapath: latched word, message priority and completion status.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_PEND     <= 1'b0;
            PRIORITY    <= 1'b0;
            msg_active  <= 1'b0;
            tx_status   <= 1'b0;
            USR_TX_SUCC <= 1'b0;
        end else begin
            if (tx_accept) begin
                TX_ADDR    <= USR_TX_ADDR;
                TX_DATA    <= USR_TX_DATA;
                TX_PEND    <= USR_TX_PEND;
                msg_active <= 1'b1;
                if (!msg_active) begin
                    PRIORITY <= USR_TX_PRIO;
                end
            end
            if (tx_abort) begin
                tx_status <= 1'b0;
            end else if (tx_state == TX_WAIT_RESP && tx_resp_s) begin
                tx_status <= resp_is_succ(tx_succ_s, tx_fail_s);
            end
            if (tx_done_nxt) begin
                USR_TX_SUCC <= tx_status;
                PRIORITY    <= 1'b0;
                msg_active  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ulpb_lc_handshake.sv
// tb/tb_ulpb_lc_handshake.sv - self-checking bench for ulpb_lc_handshake
module tb_ulpb_lc_handshake;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    // Two synchronizer stages plus one registered response.
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic [AW-1:0] RX_ADDR = '0;
    logic [DW-1:0] RX_DATA = '0;
    logic          RX_REQ = 1'b0, RX_PEND = 1'b0, RX_FAIL = 1'b0;
    logic          RX_ACK;
    logic [AW-1:0] TX_ADDR;
    logic [DW-1:0] TX_DATA;
    logic          TX_PEND, TX_REQ, PRIORITY;
    logic          TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
    logic          TX_RESP_ACK;
    logic          USR_RX_VALID;
    logic          USR_RX_READY = 1'b0;
    logic [AW-1:0] USR_RX_ADDR;
    logic [DW-1:0] USR_RX_DATA;
    logic          USR_RX_PEND, USR_RX_FAIL;
    logic          USR_TX_VALID = 1'b0;
    logic          USR_TX_READY;
    logic [AW-1:0] USR_TX_ADDR = '0;
    logic [DW-1:0] USR_TX_DATA = '0;
    logic          USR_TX_PEND = 1'b0, USR_TX_PRIO = 1'b0;
    logic          USR_TX_DONE, USR_TX_SUCC;

    ulpb_lc_handshake #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RX_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ), .RX_PEND(RX_PEND),
        .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
        .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK),
        .USR_RX_VALID(USR_RX_VALID), .USR_RX_READY(USR_RX_READY), .USR_RX_ADDR(USR_RX_ADDR),
        .USR_RX_DATA(USR_RX_DATA), .USR_RX_PEND(USR_RX_PEND), .USR_RX_FAIL(USR_RX_FAIL),
        .USR_TX_VALID(USR_TX_VALID), .USR_TX_READY(USR_TX_READY), .USR_TX_ADDR(USR_TX_ADDR),
        .USR_TX_DATA(USR_TX_DATA), .USR_TX_PEND(USR_TX_PEND), .USR_TX_PRIO(USR_TX_PRIO),
        .USR_TX_DONE(USR_TX_DONE), .USR_TX_SUCC(USR_TX_SUCC)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          p;
    } rx_word_t;

    rx_word_t rx_q[$];
    logic     exp_prio = 1'b0;
    logic     msg_first = 1'b1;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rx_send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
        rx_word_t w;
        RX_ADDR = a; RX_DATA = d; RX_PEND = p; RX_REQ = 1'b1;
        ticks(LAT - 1);
        chk("rx_ack_early", 64'(RX_ACK), 64'(0));
        tick();
        chk("rx_ack_rise", 64'(RX_ACK), 64'(1));
        w.a = a; w.d = d; w.p = p;
        rx_q.push_back(w);
    endtask

    task automatic rx_drop();
        RX_REQ = 1'b0;
        ticks(LAT - 1);
        chk("rx_ack_hold", 64'(RX_ACK), 64'(1));
        tick();
        chk("rx_ack_fall", 64'(RX_ACK), 64'(0));
    endtask

    task automatic rx_pop();
        rx_word_t w;
        w = rx_q.pop_front();
        chk("rx_head_valid", 64'(USR_RX_VALID), 64'(1));
        chk("rx_head_addr", 64'(USR_RX_ADDR), 64'(w.a));
        chk("rx_head_data", 64'(USR_RX_DATA), 64'(w.d));
        chk("rx_head_pend", 64'(USR_RX_PEND), 64'(w.p));
        USR_RX_READY = 1'b1;
        tick();
        USR_RX_READY = 1'b0;
    endtask

    task automatic tx_accept(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic p, input logic pr);
        chk("tx_ready", 64'(USR_TX_READY), 64'(1));
        USR_TX_ADDR = a; USR_TX_DATA = d; USR_TX_PEND = p; USR_TX_PRIO = pr;
        USR_TX_VALID = 1'b1;
        tick();
        USR_TX_VALID = 1'b0;
        if (msg_first) begin
            exp_prio  = pr;
            msg_first = 1'b0;
        end
        chk("tx_req_rise", 64'(TX_REQ), 64'(1));
        chk("tx_addr", 64'(TX_ADDR), 64'(a));
        chk("tx_data", 64'(TX_DATA), 64'(d));
        chk("tx_pend", 64'(TX_PEND), 64'(p));
        chk("tx_prio", 64'(PRIORITY), 64'(exp_prio));
    endtask

    task automatic tx_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic p, input logic pr);
        tx_accept(a, d, p, pr);
        TX_ACK = 1'b1;
        ticks(LAT - 1);
        chk("tx_req_hold", 64'(TX_REQ), 64'(1));
        tick();
        chk("tx_req_fall", 64'(TX_REQ), 64'(0));
        TX_ACK = 1'b0;
        ticks(LAT - 1);
        chk("tx_ready_acklo", 64'(USR_TX_READY), 64'(0));
        tick();
        chk("tx_ready_after", 64'(USR_TX_READY), 64'(p));
        chk("tx_prio_word", 64'(PRIORITY), 64'(exp_prio));
    endtask

    task automatic tx_finish(input logic exp_succ);
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        ticks(LAT - 1);
        chk("tx_resp_ack_hold", 64'(TX_RESP_ACK), 64'(1));
        chk("tx_done_early", 64'(USR_TX_DONE), 64'(0));
        tick();
        chk("tx_resp_ack_fall", 64'(TX_RESP_ACK), 64'(0));
        chk("tx_done", 64'(USR_TX_DONE), 64'(1));
        chk("tx_succ", 64'(USR_TX_SUCC), 64'(exp_succ));
        chk("tx_prio_clr", 64'(PRIORITY), 64'(0));
        tick();
        chk("tx_done_pulse", 64'(USR_TX_DONE), 64'(0));
        chk("tx_succ_held", 64'(USR_TX_SUCC), 64'(exp_succ));
        msg_first = 1'b1;
    endtask

    task automatic tx_resp(input logic s, input logic f);
        TX_SUCC = s; TX_FAIL = f;
        ticks(LAT - 1);
        chk("tx_resp_ack_early", 64'(TX_RESP_ACK), 64'(0));
        tick();
        chk("tx_resp_ack_rise", 64'(TX_RESP_ACK), 64'(1));
        tx_finish(s && !f);
    endtask

    initial begin
        logic [2:0] r;
        int         len;

        // Reset state
        ticks(3);
        chk("rst_rx_ack", 64'(RX_ACK), 64'(0));
        chk("rst_tx_req", 64'(TX_REQ), 64'(0));
        chk("rst_resp_ack", 64'(TX_RESP_ACK), 64'(0));
        chk("rst_prio", 64'(PRIORITY), 64'(0));
        chk("rst_tx_addr", 64'(TX_ADDR), 64'(0));
        chk("rst_tx_data", 64'(TX_DATA), 64'(0));
        chk("rst_rx_valid", 64'(USR_RX_VALID), 64'(0));
        chk("rst_done", 64'(USR_TX_DONE), 64'(0));
        chk("rst_succ", 64'(USR_TX_SUCC), 64'(0));
        RESETn = 1'b1;
        ticks(2);

        // RX single word
        rx_send(8'h15, 32'hDEADBEEF, 1'b0);
        rx_drop();
        rx_pop();
        chk("rx_empty", 64'(USR_RX_VALID), 64'(0));

        // RX backpressure: fill the FIFO, the next word must wait for a pop
        for (int i = 0; i < DEPTH; i++) begin
            rx_send(AW'($urandom), $urandom, 1'($urandom));
            rx_drop();
        end
        begin
            rx_word_t w5;
            w5.a = AW'($urandom); w5.d = $urandom; w5.p = 1'($urandom);
            RX_ADDR = w5.a; RX_DATA = w5.d; RX_PEND = w5.p; RX_REQ = 1'b1;
            ticks(8);
            chk("rx_full_withheld", 64'(RX_ACK), 64'(0));
            rx_pop();
            chk("rx_full_pop_edge", 64'(RX_ACK), 64'(0));
            tick();
            chk("rx_ack_after_pop", 64'(RX_ACK), 64'(1));
            rx_q.push_back(w5);
            rx_drop();
        end
        for (int i = 0; i < DEPTH; i++) rx_pop();
        chk("rx_drained", 64'(USR_RX_VALID), 64'(0));

        // RX fail pulse leaves the FIFO untouched
        rx_send(AW'($urandom), $urandom, 1'b1);
        rx_drop();
        RX_FAIL = 1'b1;
        ticks(LAT - 1);
        chk("rx_fail_early", 64'(USR_RX_FAIL), 64'(0));
        tick();
        chk("rx_fail_pulse", 64'(USR_RX_FAIL), 64'(1));
        tick();
        chk("rx_fail_end", 64'(USR_RX_FAIL), 64'(0));
        RX_FAIL = 1'b0;
        ticks(2);
        rx_pop();

        // TX two-word message with priority, success
        tx_word(AW'($urandom), $urandom, 1'b1, 1'b1);
        tx_word(AW'($urandom), $urandom, 1'b0, 1'b0);
        tx_resp(1'b1, 1'b0);

        // Early TX_FAIL while REQ is high
        tx_accept(AW'($urandom), $urandom, 1'b0, 1'($urandom));
        TX_FAIL = 1'b1;
        ticks(LAT - 1);
        chk("abort_req_hold", 64'(TX_REQ), 64'(1));
        tick();
        chk("abort_req_drop", 64'(TX_REQ), 64'(0));
        chk("abort_resp_ack", 64'(TX_RESP_ACK), 64'(1));
        tx_finish(1'b0);

        // Success then simultaneous SUCC and FAIL
        tx_word(AW'($urandom), $urandom, 1'b0, 1'($urandom));
        tx_resp(1'b1, 1'b0);
        tx_word(AW'($urandom), $urandom, 1'b0, 1'($urandom));
        tx_resp(1'b1, 1'b1);

        // Random messages: length 1..3, random priority and response
        for (int m = 0; m < 4; m++) begin
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                tx_word(AW'($urandom), $urandom, (k != len - 1), 1'($urandom));
            end
            r = 3'($urandom_range(1, 3));
            tx_resp(r[0], r[1]);
        end

        // Reset mid-RX and mid-TX
        rx_send(AW'($urandom), $urandom, 1'b0);
        tx_accept(AW'($urandom), $urandom, 1'b0, 1'b1);
        chk("pre_rst_valid", 64'(USR_RX_VALID), 64'(1));
        RESETn = 1'b0;
        #1;
        chk("mrst_rx_ack", 64'(RX_ACK), 64'(0));
        chk("mrst_tx_req", 64'(TX_REQ), 64'(0));
        chk("mrst_resp_ack", 64'(TX_RESP_ACK), 64'(0));
        chk("mrst_prio", 64'(PRIORITY), 64'(0));
        chk("mrst_tx_addr", 64'(TX_ADDR), 64'(0));
        chk("mrst_tx_data", 64'(TX_DATA), 64'(0));
        chk("mrst_tx_pend", 64'(TX_PEND), 64'(0));
        chk("mrst_rx_valid", 64'(USR_RX_VALID), 64'(0));
        rx_q.delete();
        msg_first = 1'b1;
        exp_prio  = 1'b0;
        RX_REQ = 1'b0;
        ticks(2);
        RESETn = 1'b1;
        tick();

        // Traffic after reset
        rx_send(AW'($urandom), $urandom, 1'($urandom));
        rx_drop();
        rx_pop();
        tx_word(AW'($urandom), $urandom, 1'b0, 1'($urandom));
        tx_resp(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ulpb_lc_handshake.md
# ulpb_lc_handshake

Layer-controller-side endpoint of the BC↔LC handshake. It sits in the power-gated layer domain, on the far side of the always-on isolation cells, and terminates the four-phase RX and TX handshakes driven by the bus controller. Received words are buffered in a small FIFO for layer logic. Words to transmit are accepted from layer logic and sequenced through TX_REQ/TX_ACK and the TX_SUCC/TX_FAIL response.

## Interface
- ADDR_WIDTH, 8, address width (matches `ADDR_WIDTH in ulpb_def.v)
- DATA_WIDTH, 32, data word width
- RX_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- CLK  in  1  layer clock; sole clock
- RESETn  in  1  asynchronous, active-low reset
- RX_ADDR  in  ADDR_WIDTH  address from BC; stable while RX_REQ high
- RX_DATA  in  DATA_WIDTH  data from BC; stable while RX_REQ high
- RX_REQ  in  1  BC receive request (asynchronous to CLK)
- RX_PEND  in  1  more words follow in this message; stable while RX_REQ high
- RX_FAIL  in  1  BC receive-failure level
- RX_ACK  out  1  receive acknowledge
- TX_ADDR  out  ADDR_WIDTH  transmit address
- TX_DATA  out  DATA_WIDTH  transmit data
- TX_PEND  out  1  more words follow
- TX_REQ  out  1  transmit request
- PRIORITY  out  1  priority arbitration request
- TX_ACK  in  1  BC transmit acknowledge (asynchronous)
- TX_SUCC  in  1  message success (asynchronous)
- TX_FAIL  in  1  message failure (asynchronous)
- TX_RESP_ACK  out  1  response acknowledge
- USR_RX_VALID  out  1  FIFO head valid
- USR_RX_READY  in  1  layer pops head when high with VALID
- USR_RX_ADDR  out  ADDR_WIDTH  head address
- USR_RX_DATA  out  DATA_WIDTH  head data
- USR_RX_PEND  out  1  head pend bit
- USR_RX_FAIL  out  1  one-cycle pulse on RX_FAIL rising edge
- USR_TX_VALID  in  1  layer offers a word
- USR_TX_READY  out  1  word accepted when high with VALID
- USR_TX_ADDR  in  ADDR_WIDTH  word address
- USR_TX_DATA  in  DATA_WIDTH  word data
- USR_TX_PEND  in  1  more words follow
- USR_TX_PRIO  in  1  priority request for the message
- USR_TX_DONE  out  1  one-cycle pulse at message completion
- USR_TX_SUCC  out  1  completion status; valid with DONE and held until next DONE

## Operation
- Synchronizers: RX_REQ, RX_FAIL, TX_ACK, TX_SUCC and TX_FAIL each pass through two flops. Addr/data/pend inputs are sampled directly; the protocol guarantees they are stable.
- RX FSM, states RX_IDLE → RX_ACKED:
  - RX_IDLE: when the synced RX_REQ is 1 and the FIFO is not full, push {RX_ADDR, RX_DATA, RX_PEND}, set RX_ACK=1 and move to RX_ACKED.
  - If the FIFO is full, hold RX_ACK=0 (backpressure) and stay in RX_IDLE.
  - RX_ACKED: when the synced RX_REQ is 0, set RX_ACK=0 and return to RX_IDLE.
- RX FIFO: a push and a pop in the same cycle leave the count unchanged. Pointers are log2(RX_DEPTH) bits and wrap naturally; the count is one bit wider.
- USR_RX_FAIL pulses on the synced RX_FAIL rising edge. FIFO contents are unaffected; the layer discards the partial message.
- TX FSM, states TX_IDLE, TX_REQ_HI, TX_ACK_LO, TX_WAIT_RESP, TX_RESP:
  - TX_IDLE: USR_TX_READY=1. On accept, latch addr/data/pend to TX_* and set TX_REQ=1. On the first word of a message, also latch PRIORITY from USR_TX_PRIO. Go to TX_REQ_HI.
  - TX_REQ_HI: when the synced TX_ACK is 1, set TX_REQ=0 and go to TX_ACK_LO.
  - TX_ACK_LO: when the synced TX_ACK is 0, go to TX_IDLE if the latched pend is 1, otherwise to TX_WAIT_RESP.
  - TX_WAIT_RESP: when synced TX_SUCC or TX_FAIL is 1, set TX_RESP_ACK=1 and latch status. If both are 1, FAIL wins. Go to TX_RESP.
  - TX_RESP: when both synced SUCC and FAIL are 0, set TX_RESP_ACK=0, clear PRIORITY, pulse USR_TX_DONE and return to TX_IDLE.
- A SUCC or FAIL arriving in any state other than TX_WAIT_RESP (early abort by the BC) is handled as follows:
  - Drop TX_REQ.
  - Go straight to TX_RESP with status FAIL.
  - Pulse DONE with USR_TX_SUCC=0.
- The RX and TX FSMs are independent and may be active simultaneously.

## Timing
- Reset: all outputs and FSM/FIFO state clear asynchronously to 0. RX_ACK, TX_REQ, TX_RESP_ACK, PRIORITY and TX_* are all 0, the FIFO is empty, and both FSMs are idle. Assertion mid-handshake abandons it; the BC recovers through its own reset or timeout.
- RX_REQ rise to RX_ACK rise: 3 CLK edges (2 sync + 1 register) when not full.
- Full FIFO: RX_ACK rises on the edge after the pop that frees space.
- FIFO head is visible on USR_RX_* one cycle after the push.
- TX accept to TX_REQ: 1 edge. TX_ACK rise to TX_REQ fall: 3 edges.
- USR_RX_FAIL: 3 edges after the RX_FAIL rise.

## Structure
- Shared package: RX/TX state encodings, IO_HOLD/IO_RELEASE (already in ulpb_def.v), and ADDR/DATA widths.
- Sub-module ulpb_sync2: two-flop synchronizer with async active-low reset, instantiated five times.
- The FIFO stays inline.

## Test plan
- RX single word: RX_ADDR=0x15, DATA=0xDEADBEEF, PEND=0, REQ raised → RX_ACK=1 at edge 3; drop REQ → ACK=0 at edge 3; USR_RX head shows 0x15/0xDEADBEEF.
- RX backpressure: RX_DEPTH=4, 5 words, READY=0 → 4 ACKs, 5th ACK withheld; pop one → 5th ACK on the next edge; pops return the words in order.
- TX 2-word message: PEND=1 then 0, PRIO=1 → two full REQ/ACK cycles with PRIORITY=1; TX_SUCC → RESP_ACK, DONE pulse, USR_TX_SUCC=1, PRIORITY=0.
- TX SUCC and FAIL simultaneous → DONE with USR_TX_SUCC=0.
- Early TX_FAIL during TX_REQ_HI → TX_REQ drops, RESP_ACK handshake completes, DONE with SUCC=0.
- RESETn low mid-RX (RX_ACK=1) and mid-TX → all outputs 0 immediately, FIFO empty, new transactions work afterward.
